// File: rtl/dispatch_pkg.sv
// -----------------------------------------------------------------------------
// dispatch_pkg
// Shared definitions for the demux dispatch controller.
//   state_e : controller FSM state (IDLE = no word held, HOLD = one word held)
//   LANES   : number of output lanes
//   SEL_W   : width of the lane index / demux select
// -----------------------------------------------------------------------------
package dispatch_pkg;

    localparam int LANES = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

endpackage : dispatch_pkg

// File: rtl/two_bits_select_four_demux_module.sv
// -----------------------------------------------------------------------------
// TWO_BITS_SELECT_FOUR_DEMUX_MODULE
// 1-to-4 demultiplexer: routes the single DATA bit to output bit S; all other
// outputs are 0.
// Ports:
//   DATA : input  1  bit to route
//   S    : input  2  select
//   OUT  : output 4  demuxed bits
// -----------------------------------------------------------------------------
module TWO_BITS_SELECT_FOUR_DEMUX_MODULE (
    input  logic       DATA,
    input  logic [1:0] S,
    output logic [3:0] OUT
);

    always_comb begin
        OUT = 4'b0000;
        case (S)
            2'd0:    OUT[0] = DATA;
            2'd1:    OUT[1] = DATA;
            2'd2:    OUT[2] = DATA;
            default: OUT[3] = DATA;
        endcase
    end

endmodule : TWO_BITS_SELECT_FOUR_DEMUX_MODULE

// File: rtl/demux_dispatch_controller.sv
// -----------------------------------------------------------------------------
// demux_dispatch_controller
// Holds one upstream word and dispatches it to one of four lanes, picking the
// lane round-robin among the enabled lanes. Sustains one word per cycle when
// the selected lane is ready.
//
// Handshake (valid/ready, both sides): a word moves when valid and ready are
// both high at a rising CLK edge. Valid never depends on ready. Once OUT_VALID
// is raised, OUT_DATA and SEL stay fixed until the selected lane takes it.
//
// Ports:
//   CLK        input   1       clock, rising edge
//   RST_N      input   1       asynchronous active-low reset
//   IN_VALID   input   1       upstream word valid
//   IN_DATA    input   DATA_W  upstream word
//   IN_READY   output  1       word accepted this cycle (combinational)
//   LANE_EN    input   4       per-lane dispatch enable
//   OUT_VALID  output  4       one-hot lane valid
//   OUT_DATA   output  DATA_W  held word, shared by all lanes
//   OUT_READY  input   4       per-lane ready (only the selected bit matters)
//   SEL        output  2       selected lane index
//   BUSY       output  1       high in HOLD; this is the FSM state itself
//   LANE_COUNT output  32      4x8-bit per-lane completion counters
//                              (only when DISPATCH_STATS_EN is defined)
//
// Build option: define DISPATCH_STATS_EN to add LANE_COUNT.
// -----------------------------------------------------------------------------
module demux_dispatch_controller
    import dispatch_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              IN_VALID,
    input  logic [DATA_W-1:0] IN_DATA,
    output logic              IN_READY,
    input  logic [LANES-1:0]  LANE_EN,
    output logic [LANES-1:0]  OUT_VALID,
    output logic [DATA_W-1:0] OUT_DATA,
    input  logic [LANES-1:0]  OUT_READY,
    output logic [SEL_W-1:0]  SEL,
    output logic              BUSY
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]       LANE_COUNT
`endif
);

    // First enabled lane searched from start upward, wrapping. Iterating from
    // the far end down lets the nearest hit overwrite the others. If nothing
    // is enabled the result is start, which is never used (no accept then).
    function automatic logic [SEL_W-1:0] rr_pick(input logic [LANES-1:0] en,
                                                 input logic [SEL_W-1:0] start);
        logic [SEL_W-1:0] idx;
        rr_pick = start;
        for (int k = LANES - 1; k >= 0; k--) begin
            idx = start + SEL_W'(k);
            if (en[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    ptr_q,   ptr_d;
    logic [SEL_W-1:0]    sel_q,   sel_d;
    logic [DATA_W-1:0]   data_q,  data_d;

    logic                busy;
    logic                done;
    logic                accept;
    logic [SEL_W-1:0]    search_base;
    logic [SEL_W-1:0]    cand;

    assign busy   = (state_q == HOLD);
    assign done   = busy && OUT_READY[sel_q];
    // A completing lane frees the holding slot in the same cycle, so a new
    // word may be accepted then as well.
    assign IN_READY = (!busy || OUT_READY[sel_q]) && (LANE_EN != '0);
    assign accept   = IN_VALID && IN_READY;

    // On a back-to-back transfer the pointer has not been written yet, so the
    // search starts from the value it is about to take.
    assign search_base = done ? (sel_q + SEL_W'(1)) : ptr_q;
    assign cand        = rr_pick(LANE_EN, search_base);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;

        if (done) begin
            ptr_d   = sel_q + SEL_W'(1);
            state_d = IDLE;
        end

        if (accept) begin
            state_d = HOLD;
            sel_d   = cand;
            data_d  = IN_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    assign BUSY     = busy;
    assign SEL      = sel_q;
    assign OUT_DATA = data_q;

    // Valid is derived from the state flop, so it drops as soon as reset
    // asserts, without waiting for a clock edge.
    TWO_BITS_SELECT_FOUR_DEMUX_MODULE u_valid_demux (
        .DATA (busy),
        .S    (sel_q),
        .OUT  (OUT_VALID)
    );

`ifdef DISPATCH_STATS_EN
    logic [7:0] lane_cnt_q [LANES];
    logic [7:0] lane_cnt_d [LANES];

    // 8-bit counters wrap naturally 255 -> 0.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_cnt_d[i] = lane_cnt_q[i];
        end
        if (done) begin
            lane_cnt_d[sel_q] = lane_cnt_q[sel_q] + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < LANES; i++) begin
                lane_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                lane_cnt_q[i] <= lane_cnt_d[i];
            end
        end
    end

    assign LANE_COUNT = {lane_cnt_q[3], lane_cnt_q[2], lane_cnt_q[1], lane_cnt_q[0]};
`endif

endmodule : demux_dispatch_controller

// File: tb/tb_demux_dispatch_controller.sv
// -----------------------------------------------------------------------------
// tb_demux_dispatch_controller
// Directed scenarios plus randomized traffic. A transaction-level model
// (held word, its lane, round-robin pointer) predicts outputs every cycle;
// a queue of accepted words checks delivery order.
// -----------------------------------------------------------------------------
module tb_demux_dispatch_controller;

    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [3:0]        lane_en;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [3:0]        out_ready;
    logic [1:0]        sel;
    logic              busy;
`ifdef DISPATCH_STATS_EN
    logic [31:0]       lane_count;
`endif

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    demux_dispatch_controller #(.DATA_W(DATA_W)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_DATA   (in_data),
        .IN_READY  (in_ready),
        .LANE_EN   (lane_en),
        .OUT_VALID (out_valid),
        .OUT_DATA  (out_data),
        .OUT_READY (out_ready),
        .SEL       (sel),
        .BUSY      (busy)
`ifdef DISPATCH_STATS_EN
        ,
        .LANE_COUNT(lane_count)
`endif
    );

    // ---------------- scoreboard / model ----------------
    int total = 0;
    int bad   = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                lane_q[$];

    bit                m_held;
    int                m_lane;
    logic [DATA_W-1:0] m_data;
    int                m_ptr;
    int                m_cnt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int search(input logic [3:0] en, input int start);
        for (int k = 0; k < 4; k++) begin
            if (en[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_held = 0;
        m_lane = 0;
        m_data = '0;
        m_ptr  = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        exp_q.delete();
        lane_q.delete();
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return
    // just after the rising edge so callers can drive the next inputs.
    task automatic tick();
        bit exp_rdy, done, acc;
        int cand;
        logic [DATA_W-1:0] w;
        int l;
        @(negedge clk);
        exp_rdy = (!m_held || out_ready[m_lane]) && (lane_en != 4'd0);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {28'd0, out_valid}, m_held ? (32'd1 << m_lane) : 32'd0);
        chk("busy", {31'd0, busy}, {31'd0, m_held});
        if (m_held) begin
            chk("out_data", {24'd0, out_data}, {24'd0, m_data});
            chk("sel", {30'd0, sel}, m_lane);
        end
`ifdef DISPATCH_STATS_EN
        for (int i = 0; i < 4; i++) begin
            chk("lane_count", (lane_count >> (8 * i)) & 32'hFF, m_cnt[i]);
        end
`endif
        done = m_held && out_ready[m_lane];
        acc  = in_valid && exp_rdy;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("delivery_queue", 32'd0, 32'd1);
            end else begin
                w = exp_q.pop_front();
                l = lane_q.pop_front();
                chk("delivered_data", {24'd0, out_data}, {24'd0, w});
                chk("delivered_lane", {30'd0, sel}, l);
            end
            m_ptr = (m_lane + 1) % 4;
            m_cnt[m_lane] = (m_cnt[m_lane] + 1) % 256;
            m_held = 0;
        end
        if (acc) begin
            cand = search(lane_en, m_ptr);
            m_held = 1;
            m_lane = cand;
            m_data = in_data;
            exp_q.push_back(in_data);
            lane_q.push_back(cand);
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, release just after a rising edge so the
    // very next edge can accept.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sel", {30'd0, sel}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        lane_en   = 4'b0000;
        out_ready = 4'b0000;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Full enable, all ready: lanes 0..3 back to back, first edge after reset.
        lane_en   = 4'b1111;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 8'hA0 + 8'(i);
            tick();
            chk("seq_sel", {30'd0, sel}, i);
            chk("seq_valid", {28'd0, out_valid}, 32'd1 << i);
            chk("seq_data", {24'd0, out_data}, 32'hA0 + i);
        end
        in_valid = 1'b0;
        tick();
        chk("seq_drained", {31'd0, busy}, 32'd0);

        // Sparse enable 0101 from pointer 0: lanes 0,2,0.
        do_reset();
        lane_en   = 4'b0101;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
            chk("sparse_sel", {30'd0, sel}, (i == 1) ? 2 : 0);
            chk("sparse_no_odd", {28'd0, out_valid & 4'b1010}, 32'd0);
        end
        in_valid = 1'b0;
        tick();

        // Stall on lane 1 while other lanes are ready.
        do_reset();
        lane_en   = 4'b0010;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        tick();
        chk("stall_load_sel", {30'd0, sel}, 32'd1);
        lane_en   = 4'b1111;
        out_ready = 4'b1101;
        in_data   = 8'h66;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_data", {24'd0, out_data}, 32'h55);
            chk("stall_sel", {30'd0, sel}, 32'd1);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 4'b1111;
        tick();
        chk("after_stall_sel", {30'd0, sel}, 32'd2);
        chk("after_stall_data", {24'd0, out_data}, 32'h66);
        in_valid = 1'b0;
        tick();

        // No lane enabled: nothing accepted, then only lane 3.
        lane_en  = 4'b0000;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("noen_in_ready", {31'd0, in_ready}, 32'd0);
            chk("noen_valid", {28'd0, out_valid}, 32'd0);
        end
        lane_en = 4'b1000;
        tick();
        chk("lane3_sel", {30'd0, sel}, 32'd3);
        in_valid = 1'b0;
        tick();

        // Reset while holding on lane 2: word discarded, next goes to lane 0.
        lane_en   = 4'b0100;
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        tick();
        chk("hold2_sel", {30'd0, sel}, 32'd2);
        in_valid = 1'b0;
        tick();
        do_reset();
        lane_en   = 4'b1111;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        in_data   = 8'h88;
        tick();
        chk("post_rst_sel", {30'd0, sel}, 32'd0);
        chk("post_rst_data", {24'd0, out_data}, 32'h88);
        in_valid = 1'b0;
        tick();

`ifdef DISPATCH_STATS_EN
        // 257 completions on lane 0: counter wraps to 1.
        do_reset();
        lane_en   = 4'b0001;
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("stats_wrap", lane_count, 32'h0000_0001);
`endif

        // Randomized traffic with occasional mid-run resets.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom_range(0, 255));
            lane_en   = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            out_ready = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux_dispatch_controller
